// File: rtl/mem_pkg.sv
// Shared types and defaults for the burst initiator and its read-return pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 8;
   localparam int LEN_W     = 4;
   localparam int MEM_DEPTH = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/mem_rd_return.sv
// Read-return pipe: delays the read strobe and last flag by one cycle to line up with mem_rdata.
// Latency: 1 cycle from mem_rd_en to rd_out_valid; data passes straight through.
// Backpressure: none; the consumer must take every beat.
module mem_rd_return #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en_i,
   input  logic              rd_last_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              rd_out_valid_o,
   output logic [DATA_W-1:0] rd_out_data_o,
   output logic              rd_out_last_o
);

   logic valid_q;
   logic last_q;

   // Track which cycles carry returned read data and which beat is the final one.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= rd_en_i;
         last_q  <= rd_en_i & rd_last_i;
      end
   end

   assign rd_out_valid_o = valid_q;
   assign rd_out_last_o  = last_q;
   // Zero the data lane outside valid beats so idle cycles show no stale memory data.
   assign rd_out_data_o  = valid_q ? mem_rdata_i : '0;

endmodule

// File: rtl/mem_burst_initiator.sv
// Burst initiator for a 1024x8 single-port synchronous memory; optional beat counters under MEM_INIT_STATS_EN.
// Latency: write beats go to the memory in the cycle they are accepted; read data returns 2 cycles after the command.
// Backpressure: cmd_ready only in IDLE; wr_in_ready throughout a write burst; read return has no backpressure.
module mem_burst_initiator #(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int LEN_W  = mem_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_in_valid,
   output logic              wr_in_ready,
   input  logic [DATA_W-1:0] wr_in_data,
   output logic              rd_out_valid,
   output logic [DATA_W-1:0] rd_out_data,
   output logic              rd_out_last,
   output logic              busy,
   output logic              mem_wr_en,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_INIT_STATS_EN
   ,
   output logic [15:0]       stat_wr_beats,
   output logic [15:0]       stat_rd_beats
`endif
);

   import mem_pkg::*;

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [LEN_W-1:0]  cnt_d;
   logic              wr_beat;
   logic              rd_beat;
   logic              final_beat;

   // A write beat happens only when data is offered; read beats issue every READ cycle.
   assign wr_beat    = (state_q == WRITE) & wr_in_valid;
   assign rd_beat    = (state_q == READ);
   assign final_beat = (cnt_q == len_q);
   // Address wraps naturally at 2^ADDR_W.
   assign addr_d     = addr_q + 1'b1;
   assign cnt_d      = cnt_q + 1'b1;

   // Burst sequencer: latch the command in IDLE, then walk address and beat count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  len_q   <= cmd_len;
                  cnt_q   <= '0;
                  state_q <= cmd_write ? WRITE : READ;
               end
            end
            WRITE: begin
               if (wr_in_valid) begin
                  addr_q <= addr_d;
                  cnt_q  <= cnt_d;
                  if (final_beat) begin
                     state_q <= IDLE;
                  end
               end
            end
            READ: begin
               addr_q <= addr_d;
               cnt_q  <= cnt_d;
               if (final_beat) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               // Final read data is returning this cycle; nothing left to issue.
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign wr_in_ready = (state_q == WRITE);
   // Strobes decode from the state, so wr_en and rd_en are mutually exclusive by construction.
   assign mem_wr_en   = wr_beat;
   assign mem_rd_en   = rd_beat;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wr_beat ? wr_in_data : '0;

   mem_rd_return #(
      .DATA_W (DATA_W)
   ) u_rd_return (
      .clk            (clk),
      .reset          (reset),
      .rd_en_i        (rd_beat),
      .rd_last_i      (final_beat),
      .mem_rdata_i    (mem_rdata),
      .rd_out_valid_o (rd_out_valid),
      .rd_out_data_o  (rd_out_data),
      .rd_out_last_o  (rd_out_last)
   );

`ifdef MEM_INIT_STATS_EN
   logic [15:0] stat_wr_q;
   logic [15:0] stat_rd_q;

   // Saturating counters of write strobes and returned read beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_wr_q <= '0;
         stat_rd_q <= '0;
      end else begin
         if (mem_wr_en && (stat_wr_q != 16'hFFFF)) begin
            stat_wr_q <= stat_wr_q + 16'd1;
         end
         if (rd_out_valid && (stat_rd_q != 16'hFFFF)) begin
            stat_rd_q <= stat_rd_q + 16'd1;
         end
      end
   end

   assign stat_wr_beats = stat_wr_q;
   assign stat_rd_beats = stat_rd_q;
`endif

endmodule

// File: doc/mem_burst_initiator.md
Name: mem_burst_initiator

Overview:
- Initiator-side controller for the single-port 1024x8 synchronous memory.
- Accepts burst commands over a valid/ready handshake and sequences per-beat memory strobes, address and write data.
- Streams write data in and read data out.
- Sits between test or DMA logic and the memory macro; it is the only driver of the memory's wr_en/rd_en/address/wdata.

Parameters:
- ADDR_W, 10, memory address width (1024 locations)
- DATA_W, 8, memory data width
- LEN_W, 4, burst length field width; a burst is cmd_len+1 beats (1..16)

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  LEN_W  beats minus one
- wr_in_valid  in  1  write-data beat offered
- wr_in_ready  out  1  write beat accepted this cycle
- wr_in_data  in  DATA_W  write-data beat
- rd_out_valid  out  1  read beat valid (no backpressure)
- rd_out_data  out  DATA_W  read beat
- rd_out_last  out  1  final beat of read burst
- busy  out  1  burst in progress (state != IDLE)
- mem_wr_en  out  1  to memory wr_en
- mem_rd_en  out  1  to memory rd_en
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory wdata
- mem_rdata  in  DATA_W  from memory rdata; registered, valid 1 cycle after the read strobe

Behaviour:
- Reset values:
  - All outputs 0, except cmd_ready = 1.
  - State = IDLE; beat counter = 0.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch addr/len/write and go to WRITE or READ next cycle.
  - Memory strobes stay 0 in IDLE.
- WRITE:
  - wr_in_ready = 1.
  - Each cycle with wr_in_valid: mem_wr_en = 1, mem_addr = current addr, mem_wdata = wr_in_data (combinational pass of the accepted beat, registered at the memory).
  - Address then increments and the beat counter increments.
  - Cycles without wr_in_valid are idle gaps: mem_wr_en = 0 and the address holds.
  - After beat cmd_len+1, return to IDLE.
- READ:
  - Each cycle: mem_rd_en = 1, mem_wr_en = 0, mem_addr = current addr, then increment. No gaps.
  - After issuing beat cmd_len+1, go to DRAIN.
- DRAIN:
  - One cycle to capture the final read, then IDLE.
- Read return:
  - rd_out_valid is a 1-cycle-delayed copy of mem_rd_en; rd_out_data = mem_rdata in that cycle.
  - rd_out_last is high with the beat matching the final issued address.
  - Latency: rd_out_valid rises 2 cycles after the command handshake.
- mem_wr_en and mem_rd_en are never high together.
  - mem_wr_en must be 0 during reads: the memory reads only when wr_en is low.
- Address arithmetic is modulo 2^ADDR_W: 1023 + 1 wraps to 0 within a burst.
- Back-to-back commands: cmd_ready returns high the cycle after the last write beat or after DRAIN; a new command is accepted that cycle.
- Reset mid-burst:
  - Abandon immediately; the partial burst is not completed and not reported.
  - Strobes drop to 0 the next cycle; writes already performed remain in memory.
- cmd_valid while busy is ignored (cmd_ready = 0); the holder keeps it asserted.

Optional Feature:
- Macro MEM_INIT_STATS_EN.
- Defined:
  - Adds outputs stat_wr_beats and stat_rd_beats, 16 bits each.
  - They count memory write strobes and read beats returned, saturate at 0xFFFF, and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_pkg:
  - ADDR_W/DATA_W/LEN_W defaults
  - state enum type (IDLE, WRITE, READ, DRAIN)
  - MEM_DEPTH = 1024
- Natural sub-module: mem_rd_return, the 1-cycle valid/last delay pipe that pairs mem_rdata with rd_out_valid/rd_out_last.
- The FSM and address counter stay in the top.

Test Plan:
- Write burst: cmd_write=1, addr=0x010, len=3, data 0xA1..0xA4 continuous → mem_wr_en high 4 cycles at addresses 0x010..0x013; cmd_ready low 4 cycles, then high.
- Read burst: cmd_write=0, addr=0x010, len=3 after the above → rd_out_data 0xA1,0xA2,0xA3,0xA4 on 4 consecutive cycles; rd_out_last only on 0xA4; first valid 2 cycles after the handshake.
- Wrap: write len=3 at addr=0x3FE with data 0x11..0x14 → addresses 0x3FE,0x3FF,0x000,0x001; read back returns 0x11..0x14 in order.
- Write gaps: wr_in_valid toggles 1,0,1,0,1 for len=2 → exactly 3 mem_wr_en pulses; address holds during gaps.
- Reset mid-read: assert reset on the 2nd beat of a len=7 read → next cycle all strobes 0, rd_out_valid 0, cmd_ready 1; no rd_out_last is produced.
- With MEM_INIT_STATS_EN: run the write and read bursts above → stat_wr_beats=4, stat_rd_beats=4; preload the counter at 0xFFFF → it stays at 0xFFFF.
